// File: rtl/ascon_round_ctrl.sv
// ASCON permutation round sequencer: drives the external round counter and the datapath enable.
// Optional abort input enabled by defining ASCON_RND_ABORT_EN.
module ascon_round_ctrl #(
  parameter int unsigned ROUND_W   = 4,
  parameter int unsigned PA_ROUNDS = 12,
  parameter int unsigned PB_ROUNDS = 6
) (
  input  logic               clock_i,
  input  logic               resetb_i,
  input  logic               start_i,
  input  logic               mode_i,
  input  logic [ROUND_W-1:0] cnt_i,
  output logic               cnt_en_o,
  output logic               cnt_init_o,
  output logic [ROUND_W-1:0] round_idx_o,
  output logic               perm_en_o,
  output logic               busy_o,
  output logic               done_o
`ifdef ASCON_RND_ABORT_EN
  ,
  input  logic               abort_i
`endif
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic [ROUND_W-1:0] PaN = ROUND_W'(PA_ROUNDS);
  localparam logic [ROUND_W-1:0] PbN = ROUND_W'(PB_ROUNDS);
  localparam logic [ROUND_W-1:0] One = ROUND_W'(1);

  state_e             r_state;
  state_e             w_next_state;
  logic [ROUND_W-1:0] r_n;
  logic               w_start;
  logic               w_last;
  logic               w_abort;

`ifdef ASCON_RND_ABORT_EN
  assign w_abort = abort_i;
`else
  assign w_abort = 1'b0;
`endif

  // A start seen while reset is asserted must not enable the counter.
  assign w_start = start_i & resetb_i;
  // Counter values beyond N-1 are a fault; exit rather than hang.
  assign w_last  = (cnt_i >= (r_n - One));

  always_ff @(posedge clock_i) begin
    if (!resetb_i) begin
      r_state <= StIdle;
      r_n     <= PaN;
    end else begin
      r_state <= w_next_state;
      if ((r_state == StIdle) && start_i) begin
        r_n <= mode_i ? PbN : PaN;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    cnt_en_o     = 1'b0;
    cnt_init_o   = 1'b0;
    round_idx_o  = '0;
    perm_en_o    = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_start) begin
          cnt_en_o     = 1'b1;
          cnt_init_o   = 1'b1;
          w_next_state = StRun;
        end
      end
      StRun: begin
        busy_o      = 1'b1;
        round_idx_o = (PaN - r_n) + cnt_i;
        if (w_abort) begin
          w_next_state = StIdle;
        end else begin
          cnt_en_o  = 1'b1;
          perm_en_o = 1'b1;
          if (w_last) begin
            w_next_state = StDone;
          end
        end
      end
      StDone: begin
        done_o       = 1'b1;
        w_next_state = StIdle;
      end
      default: begin
        w_next_state = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_ascon_round_ctrl.sv
// Self-checking bench for ascon_round_ctrl with a behavioural round counter and a
// queue-based reference model of per-cycle expected outputs.
module tb_ascon_round_ctrl;

  localparam int PA = 12;
  localparam int PB = 6;

  logic       clk = 1'b0;
  logic       resetb = 1'b0;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [3:0] cnt = 4'd0;
  logic       cnt_en, cnt_init, perm_en, busy, done;
  logic [3:0] idx;
  logic       ab_now;
`ifdef ASCON_RND_ABORT_EN
  logic       abort = 1'b0;
`endif

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;

  typedef struct packed {
    logic       en;
    logic       init;
    logic       perm;
    logic       busy;
    logic       done;
    logic [3:0] idx;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  ascon_round_ctrl #(
    .ROUND_W  (4),
    .PA_ROUNDS(PA),
    .PB_ROUNDS(PB)
  ) dut (
    .clock_i    (clk),
    .resetb_i   (resetb),
    .start_i    (start),
    .mode_i     (mode),
    .cnt_i      (cnt),
    .cnt_en_o   (cnt_en),
    .cnt_init_o (cnt_init),
    .round_idx_o(idx),
    .perm_en_o  (perm_en),
    .busy_o     (busy),
    .done_o     (done)
`ifdef ASCON_RND_ABORT_EN
    ,
    .abort_i    (abort)
`endif
  );

  // Round counter following the en/init contract.
  always @(posedge clk) begin
    if (cnt_en) cnt <= cnt_init ? 4'd0 : cnt + 4'd1;
  end

  always_comb begin
    ab_now = 1'b0;
`ifdef ASCON_RND_ABORT_EN
    ab_now = abort;
`endif
  end

  // Reference model: an accepted start schedules N run cycles then one done cycle.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!resetb) begin
      q.delete();
    end else if (q.size() == 0) begin
      if (start) begin
        int n;
        n = mode ? PB : PA;
        for (int k = 0; k < n; k++) q.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'(PA - n + k)});
        q.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0});
      end
    end else if (ab_now && q[0].busy) begin
      q.delete();
    end else begin
      void'(q.pop_front());
    end
  end

  function automatic exp_t expected();
    exp_t e;
    if (q.size() == 0) begin
      e = '0;
      e.en   = start & resetb;
      e.init = start & resetb;
    end else begin
      e = q[0];
      if (ab_now && e.busy) begin
        e.en   = 1'b0;
        e.perm = 1'b0;
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      exp_t e, a;
      e = expected();
      a = '{cnt_en, cnt_init, perm_en, busy, done, idx};
      vectors++;
      if (a !== e) begin
        errors++;
        $display("FAIL model cyc=%0d got en/init/perm/busy/done/idx=%b%b%b%b%b/%0d want %b%b%b%b%b/%0d",
                 cyc, a.en, a.init, a.perm, a.busy, a.done, a.idx,
                 e.en, e.init, e.perm, e.busy, e.done, e.idx);
      end
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // Directed run from IDLE with literal expectations; optionally toggles mode during RUN.
  task automatic run_check(input logic m, input bit toggle);
    int n, base;
    n    = m ? 6 : 12;
    base = m ? 6 : 0;
    @(posedge clk); #1; start = 1'b1; mode = m;
    @(negedge clk);
    check("accept_en_init", {30'd0, cnt_en, cnt_init}, 3);
    @(posedge clk); #1; start = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check("run_idx", int'(idx), base + k);
      check("run_perm_busy", {30'd0, perm_en, busy}, 3);
      if (toggle) mode = ~mode;
    end
    @(negedge clk);
    check("done_pulse", {29'd0, done, perm_en, busy}, 4);
    @(negedge clk);
    check("done_clear", {31'd0, done}, 0);
  endtask

  task automatic wait_done(output int t);
    int k;
    k = 0;
    t = -1;
    while (k < 40) begin
      @(negedge clk);
      if (done) begin
        t = cyc;
        break;
      end
      k++;
    end
    if (t < 0) check("done_timeout", 0, 1);
  endtask

  initial begin
    int t1, t2;
    // Reset with start asserted: no counter enable.
    resetb = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_outputs", {26'd0, cnt_en, cnt_init, perm_en, busy, done, |idx}, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_outputs2", {26'd0, cnt_en, cnt_init, perm_en, busy, done, |idx}, 0);
    @(posedge clk); #1; resetb = 1'b1; start = 1'b0;

    run_check(1'b0, 1'b0);
    run_check(1'b1, 1'b1);

    // Back-to-back p^a with start held.
    @(posedge clk); #1; start = 1'b1; mode = 1'b0;
    wait_done(t1);
    @(negedge clk);
    check("b2b_reinit", {30'd0, cnt_en, cnt_init}, 3);
    @(negedge clk);
    check("b2b_idx0", int'(idx), 0);
    wait_done(t2);
    check("b2b_period", t2 - t1, 14);
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset during cycle t+4 of p^a.
    start = 1'b1; mode = 1'b0;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1; resetb = 1'b0;
    @(posedge clk); #1; resetb = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("midrst_idle", {30'd0, busy, done}, 0);
    end
    run_check(1'b0, 1'b0);

`ifdef ASCON_RND_ABORT_EN
    @(posedge clk); #1; abort = 1'b1;
    @(negedge clk);
    check("abort_idle", {31'd0, busy}, 0);
    abort = 1'b0; start = 1'b1; mode = 1'b0;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; abort = 1'b1;
    @(negedge clk);
    check("abort_perm", {30'd0, perm_en, cnt_en}, 0);
    @(posedge clk); #1; abort = 1'b0;
    @(negedge clk);
    check("abort_idle_next", {30'd0, busy, done}, 0);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      start  = ($urandom_range(0, 3) == 0);
      mode   = 1'($urandom);
      resetb = ($urandom_range(0, 199) != 0);
`ifdef ASCON_RND_ABORT_EN
      abort  = ($urandom_range(0, 29) == 0);
`endif
    end
    @(posedge clk); #1; resetb = 1'b1; start = 1'b0;
`ifdef ASCON_RND_ABORT_EN
    abort = 1'b0;
`endif
    repeat (20) @(posedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
